// File: rtl/pointer_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pointer_stream_scheduler
// Purpose  : Round-robin share of one pointer-read command channel plus input
//            stream among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module pointer_stream_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LOG_NUM_REQ = 2,
    parameter int W_D         = 32,
    parameter int W_COMM_D    = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*W_D-1:0] req_size,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   out_valid,
    output logic [W_D-1:0]         out_data,
    output logic                   out_last,
    output logic                   done,
    output logic [W_D-1:0]         done_ptr,
    output logic [31:0]            done_cycles,
    output logic [W_COMM_D-1:0]    comm_d,
    output logic                   comm_enq,
    input  logic                   comm_full,
    input  logic [W_D-1:0]         mem_q,
    output logic                   mem_deq,
    input  logic                   mem_empty
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND_ID   = 3'd1,
        S_SEND_SIZE = 3'd2,
        S_STREAM    = 3'd3,
        S_FLUSH     = 3'd4,
        S_SEND_PTR  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [LOG_NUM_REQ-1:0]  r_rr_ptr;
    logic [LOG_NUM_REQ-1:0]  r_id;
    logic [W_D-1:0]          r_size;
    logic [W_D-1:0]          r_issued;
    logic [W_D-1:0]          r_received;
    logic [W_D-1:0]          r_ptr;
    logic [31:0]             r_cycles;
    logic                    r_d_deq;
    logic                    r_last;
    logic                    w_found;
    logic [LOG_NUM_REQ-1:0]  w_idx;
    logic [LOG_NUM_REQ-1:0]  w_gnt_id;
    logic [W_D-1:0]          w_size_sel;
    logic                    w_enq;
    logic [W_COMM_D-1:0]     w_enq_data;

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = r_rr_ptr + LOG_NUM_REQ'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    always_comb begin
        w_size_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == LOG_NUM_REQ'(i)) begin
                w_size_sel = req_size[i*W_D +: W_D];
            end
        end
    end

    assign mem_deq   = (r_state == S_STREAM) && !mem_empty && (r_issued < r_size);
    assign out_valid = r_d_deq;
    // Stream data is only valid the cycle after a dequeue, so it is gated here.
    assign out_data  = r_d_deq ? mem_q : '0;
    assign out_last  = r_last;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_enq      = 1'b0;
        w_enq_data = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = (w_size_sel == '0) ? S_DONE : S_SEND_ID;
                end
            end
            S_SEND_ID: begin
                if (!comm_full) begin
                    w_enq      = 1'b1;
                    w_enq_data = W_COMM_D'(r_id);
                    w_next     = S_SEND_SIZE;
                end
            end
            S_SEND_SIZE: begin
                if (!comm_full) begin
                    w_enq      = 1'b1;
                    w_enq_data = W_COMM_D'(r_size);
                    w_next     = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_issued == r_size) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_SEND_PTR;
            S_SEND_PTR: begin
                if (!comm_full) begin
                    w_enq      = 1'b1;
                    w_enq_data = W_COMM_D'(r_ptr);
                    w_next     = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_size      <= '0;
            r_issued    <= '0;
            r_received  <= '0;
            r_ptr       <= '0;
            r_cycles    <= '0;
            r_d_deq     <= 1'b0;
            r_last      <= 1'b0;
            gnt         <= '0;
            done        <= 1'b0;
            done_ptr    <= '0;
            done_cycles <= '0;
            comm_d      <= '0;
            comm_enq    <= 1'b0;
        end else begin
            r_d_deq  <= mem_deq;
            r_last   <= mem_deq && (r_issued == r_size - W_D'(1));
            done     <= 1'b0;
            comm_enq <= w_enq;
            if (w_enq) begin
                comm_d <= w_enq_data;
            end
            if (r_state != S_IDLE) begin
                r_cycles <= r_cycles + 32'd1;
            end
            if (mem_deq) begin
                r_issued <= r_issued + W_D'(1);
            end
            if (r_d_deq) begin
                r_received <= r_received + W_D'(1);
                if (r_received == '0) begin
                    r_ptr <= mem_q;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id       <= w_gnt_id;
                        r_size     <= w_size_sel;
                        gnt        <= NUM_REQ'(1) << w_gnt_id;
                        r_cycles   <= '0;
                        r_issued   <= '0;
                        r_received <= '0;
                        r_ptr      <= '0;
                    end
                end
                S_DONE: begin
                    done        <= 1'b1;
                    done_ptr    <= r_ptr;
                    done_cycles <= r_cycles + 32'd1;
                    gnt         <= '0;
                    r_rr_ptr    <= r_id + LOG_NUM_REQ'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pointer_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pointer_stream_scheduler
// Purpose  : Directed table, corner sequences and randomized transactions
//            against a queue-based model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pointer_stream_scheduler;

    localparam int NR = 4;
    localparam int WD = 32;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NR-1:0]   req;
    logic [NR*WD-1:0] req_size;
    logic [NR-1:0]   gnt;
    logic            out_valid;
    logic [WD-1:0]   out_data;
    logic            out_last;
    logic            done;
    logic [WD-1:0]   done_ptr;
    logic [31:0]     done_cycles;
    logic [31:0]     comm_d;
    logic            comm_enq;
    logic            comm_full;
    logic [WD-1:0]   mem_q;
    logic            mem_deq;
    logic            mem_empty = 1'b1;

    pointer_stream_scheduler #(
        .NUM_REQ(NR), .LOG_NUM_REQ(2), .W_D(WD), .W_COMM_D(32)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_size(req_size), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .done(done), .done_ptr(done_ptr), .done_cycles(done_cycles),
        .comm_d(comm_d), .comm_enq(comm_enq), .comm_full(comm_full),
        .mem_q(mem_q), .mem_deq(mem_deq), .mem_empty(mem_empty)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [31:0] stream_q[$];
    logic [31:0] comm_log[$];
    logic [32:0] out_log[$];
    int gcount = 0, done_count = 0;
    int viol_full = 0, viol_empty = 0, viol_gnt = 0;
    int bubble_pct = 0;
    int model_rr = 0;
    bit tog = 1'b0;
    bit full_prev = 1'b0;

    typedef struct {
        logic [3:0]  m;
        logic [31:0] size;
        logic [31:0] base;
        int          bubble;
        int          exp_id;
        int          exp_cycles;
    } vec_t;

    // Stream source: a word appears on mem_q the cycle after it is dequeued.
    always @(posedge CLK) begin
        if (mem_deq && mem_empty) viol_empty++;
        if (mem_deq && stream_q.size() > 0) mem_q <= stream_q.pop_front();
        else                                mem_q <= 32'hDEAD_BEEF;
        full_prev = comm_full;
    end

    always @(negedge CLK) begin
        tog = !tog;
        if (bubble_pct < 0) mem_empty = tog || (stream_q.size() == 0);
        else mem_empty = ($urandom_range(0, 99) < bubble_pct) || (stream_q.size() == 0);
    end

    always @(negedge CLK) begin
        if (comm_enq) comm_log.push_back(comm_d);
        if (out_valid) out_log.push_back({out_last, out_data});
        if (gnt != '0) gcount++;
        if (done) done_count++;
        if (comm_enq && full_prev) viol_full++;
        if (!$onehot0(gnt)) viol_gnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int arb(input logic [3:0] m, input int rr);
        for (int k = 0; k < NR; k++) if (m[(rr + k) % NR]) return (rr + k) % NR;
        return 0;
    endfunction

    // Called on a negedge while the scheduler is idle; returns on the done negedge.
    task automatic run_txn(input string name, input logic [3:0] m, input logic [127:0] szv,
                           input logic [31:0] base, input int exp_id, input int exp_cycles,
                           input int bub);
        logic [31:0] sz;
        int t;
        sz = szv[exp_id*32 +: 32];
        comm_log.delete();
        out_log.delete();
        gcount = 0;
        bubble_pct = bub;
        for (int i = 0; i < int'(sz); i++) stream_q.push_back(base + 32'(i));
        req = m;
        req_size = szv;
        @(negedge CLK);
        chk({name, "_gnt"}, 64'(gnt), 64'(4'b0001 << exp_id));
        req = 4'($urandom);
        req_size = {$urandom, $urandom, $urandom, $urandom};
        t = 0;
        while (!done && t < 3000) begin
            @(negedge CLK);
            t++;
        end
        chk({name, "_done_seen"}, 64'(done), 64'd1);
        chk({name, "_done_ptr"}, 64'(done_ptr), (sz != 0) ? 64'(base) : 64'd0);
        chk({name, "_done_cycles"}, 64'(done_cycles),
            (exp_cycles >= 0) ? 64'(exp_cycles) : 64'(gcount));
        chk({name, "_enq_count"}, 64'(comm_log.size()), (sz != 0) ? 64'd3 : 64'd0);
        if (sz != 0 && comm_log.size() == 3) begin
            chk({name, "_enq_id"}, 64'(comm_log[0]), 64'(exp_id));
            chk({name, "_enq_size"}, 64'(comm_log[1]), 64'(sz));
            chk({name, "_enq_ptr"}, 64'(comm_log[2]), 64'(base));
        end
        chk({name, "_beats"}, 64'(out_log.size()), 64'(sz));
        for (int i = 0; i < int'(sz) && i < out_log.size(); i++)
            chk({name, "_beat"}, 64'(out_log[i]), 64'({(i == int'(sz) - 1), base + 32'(i)}));
        model_rr = (exp_id + 1) % NR;
        bubble_pct = 0;
        req = '0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int c0, d0, t2, eid;
        logic [3:0] rm;
        logic [127:0] rsz;

        vecs[0] = '{4'b1011, 32'd1, 32'h200, 0, 0, 7};
        vecs[1] = '{4'b1011, 32'd1, 32'h210, 0, 1, 7};
        vecs[2] = '{4'b1011, 32'd1, 32'h220, 0, 3, 7};
        vecs[3] = '{4'b1011, 32'd1, 32'h230, 0, 0, 7};
        vecs[4] = '{4'b0100, 32'd0, 32'h240, 0, 2, 1};
        vecs[5] = '{4'b0001, 32'd4, 32'h100, 0, 0, 10};
        vecs[6] = '{4'b0010, 32'd3, 32'h300, -1, 1, -1};

        req = '0;
        req_size = '0;
        comm_full = 1'b0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_ctrl", 64'({gnt, out_valid, out_last, done, comm_enq, mem_deq}), 64'd0);
        chk("rst_data", {out_data, done_ptr}, 64'd0);
        chk("rst_cnt", {done_cycles, comm_d}, 64'd0);
        RST = 1'b0;
        model_rr = 0;

        foreach (vecs[i]) begin
            chk("table_model_id", 64'(arb(vecs[i].m, model_rr)), 64'(vecs[i].exp_id));
            run_txn($sformatf("vec%0d", i), vecs[i].m, {4{vecs[i].size}}, vecs[i].base,
                    vecs[i].exp_id, vecs[i].exp_cycles, vecs[i].bubble);
        end

        // Channel full for 5 cycles in SEND_SIZE and again in SEND_PTR.
        fork
            run_txn("bp", 4'b0100, {4{32'd2}}, 32'h600, 2, 18, 0);
            begin
                t2 = 0;
                do begin @(negedge CLK); t2++; end while (!comm_enq && t2 < 100);
                comm_full = 1'b1;
                repeat (5) @(negedge CLK);
                comm_full = 1'b0;
                t2 = 0;
                do begin @(negedge CLK); t2++; end while (!(out_valid && out_last) && t2 < 100);
                comm_full = 1'b1;
                repeat (7) @(negedge CLK);
                comm_full = 1'b0;
            end
        join

        // Reset in the middle of an 8-word stream.
        comm_log.delete();
        out_log.delete();
        for (int i = 0; i < 8; i++) stream_q.push_back(32'h400 + 32'(i));
        req = 4'b0001;
        req_size = {4{32'd8}};
        @(negedge CLK);
        chk("mrst_gnt", 64'(gnt), 64'd1);
        req = '0;
        t2 = 0;
        while (out_log.size() < 3 && t2 < 200) begin @(negedge CLK); t2++; end
        chk("mrst_words_before", 64'(out_log.size()), 64'd3);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_ctrl", 64'({gnt, out_valid, out_last, done, comm_enq, mem_deq}), 64'd0);
        chk("mrst_data", {out_data, done_ptr}, 64'd0);
        chk("mrst_cnt", {done_cycles, comm_d}, 64'd0);
        RST = 1'b0;
        stream_q.delete();
        c0 = comm_log.size();
        d0 = done_count;
        repeat (10) @(negedge CLK);
        chk("mrst_no_done", 64'(done_count), 64'(d0));
        chk("mrst_no_enq", 64'(comm_log.size()), 64'(c0));
        model_rr = 0;
        run_txn("post_rst", 4'b0010, {4{32'd1}}, 32'h500, 1, 7, 0);

        for (int n = 0; n < 40; n++) begin
            rm = 4'($urandom_range(1, 15));
            rsz = {32'($urandom_range(0, 6)), 32'($urandom_range(0, 6)),
                   32'($urandom_range(0, 6)), 32'($urandom_range(0, 6))};
            eid = arb(rm, model_rr);
            run_txn($sformatf("rnd%0d", n), rm, rsz, $urandom, eid, -1,
                    int'($urandom_range(0, 60)));
        end

        repeat (3) @(negedge CLK);
        chk("enq_while_full", 64'(viol_full), 64'd0);
        chk("deq_while_empty", 64'(viol_empty), 64'd0);
        chk("gnt_onehot", 64'(viol_gnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
